// File: rtl/mem_system_pkg.sv
// Shared geometry, FSM encoding and memory timing for the cached memory system.
// Field widths follow the 16-bit byte address split {tag, index, word, byte}.
package mem_system_pkg;

    localparam int TAG         = 8;
    localparam int INDEX       = 5;
    localparam int WORD        = 2;
    localparam int WAYS        = 2;
    localparam int SETS        = 1 << INDEX;
    localparam int LINE_WORDS  = 1 << WORD;
    localparam int MEM_AW      = TAG + INDEX + WORD;
    localparam int MEM_LATENCY = 2;

    typedef enum logic [3:0] {
        IDLE,
        WB0, WB1, WB2, WB3,
        RD0, RD1, RD2, RD3,
        WAIT0, WAIT1,
        DONE
    } state_t;

    // Word of the line that a write-back or fill state operates on.
    function automatic logic [WORD-1:0] op_word(state_t s);
        case (s)
            WB1, RD1: return 2'd1;
            WB2, RD2: return 2'd2;
            WB3, RD3: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/main_mem.sv
// Word-addressed main memory with a fixed MEM_LATENCY read pipeline.
// Contents survive rst; only the read-valid pipeline is cleared.
module main_mem import mem_system_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [MEM_AW-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              rvalid
);

    logic [15:0]            mem_q [1 << MEM_AW];
    logic [15:0]            data_pipe [MEM_LATENCY];
    logic [MEM_LATENCY-1:0] valid_pipe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[MEM_LATENCY-2:0], rd};
        end
    end

    // Writes are blocked while reset is held so an aborted write-back stops cleanly.
    always_ff @(posedge clk) begin
        if (rst && wr) begin
            mem_q[addr] <= wdata;
        end
        data_pipe[0] <= mem_q[addr];
        for (int i = 1; i < MEM_LATENCY; i++) begin
            data_pipe[i] <= data_pipe[i-1];
        end
    end

    assign rdata  = data_pipe[MEM_LATENCY-1];
    assign rvalid = valid_pipe[MEM_LATENCY-1];

endmodule

// File: rtl/mem_system.sv
// 2-way set-associative write-back, write-allocate cache in front of main_mem.
// Hits complete combinationally in IDLE; misses walk write-back, fill and DONE states.
module mem_system import mem_system_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit
);

    logic [TAG-1:0]   tag;
    logic [INDEX-1:0] idx;
    logic [WORD-1:0]  word;
    logic             req, hit0, hit1, hit, hit_way, victim, victim_dirty;
    logic             unused_addr_lsb;

    logic [15:0]               data_q [WAYS][SETS][LINE_WORDS];
    logic [TAG-1:0]            tag_q [WAYS][SETS];
    logic [WAYS-1:0][SETS-1:0] valid_q, dirty_q;
    logic [SETS-1:0]           lru_q;

    state_t          state_q, next_state;
    logic            victim_q;
    logic [WORD-1:0] fill_cnt_q, op_wd;

    logic              mem_rd, mem_wr, mem_rvalid;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_wdata, mem_rdata;
    logic              done_c, stall_c, hit_c;
    logic [15:0]       data_c;

    assign tag             = Addr[15:8];
    assign idx             = Addr[7:3];
    assign word            = Addr[2:1];
    assign unused_addr_lsb = Addr[0];
    assign req             = Rd | Wr;

    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    // Fill invalid ways in order; once both are valid the LRU bit names the victim.
    assign victim       = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
    assign victim_dirty = valid_q[victim][idx] & dirty_q[victim][idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
            victim_q   <= 1'b0;
            fill_cnt_q <= '0;
        end else begin
            state_q <= next_state;
            if (state_q == IDLE) begin
                fill_cnt_q <= '0;
                if (req && hit) begin
                    lru_q[idx] <= ~hit_way;
                    if (Wr) dirty_q[hit_way][idx] <= 1'b1;
                end
                if (req && !hit) victim_q <= victim;
            end
            if (mem_rvalid) fill_cnt_q <= fill_cnt_q + 1'b1;
            if (state_q == DONE) begin
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= Wr;
                lru_q[idx]             <= ~victim_q;
            end
        end
    end

    // Line storage is not reset; validity alone decides whether contents count.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == IDLE && Wr && hit) data_q[hit_way][idx][word] <= DataIn;
            if (mem_rvalid) data_q[victim_q][idx][fill_cnt_q] <= mem_rdata;
            if (state_q == DONE) begin
                tag_q[victim_q][idx] <= tag;
                if (Wr) data_q[victim_q][idx][word] <= DataIn;
            end
        end
    end

    always_comb begin
        next_state = state_q;
        done_c     = 1'b0;
        stall_c    = 1'b0;
        hit_c      = 1'b0;
        data_c     = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        op_wd      = op_word(state_q);
        mem_addr   = {tag, idx, op_wd};
        mem_wdata  = data_q[victim_q][idx][op_wd];
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    done_c = 1'b1;
                    hit_c  = 1'b1;
                    if (Rd) data_c = data_q[hit_way][idx][word];
                end else if (req) begin
                    stall_c    = 1'b1;
                    next_state = victim_dirty ? WB0 : RD0;
                end
            end
            WB0, WB1, WB2, WB3: begin
                stall_c  = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = {tag_q[victim_q][idx], idx, op_wd};
            end
            RD0, RD1, RD2, RD3: begin
                stall_c = 1'b1;
                mem_rd  = 1'b1;
            end
            WAIT0, WAIT1: stall_c = 1'b1;
            DONE: begin
                done_c     = 1'b1;
                next_state = IDLE;
                if (Rd) data_c = data_q[victim_q][idx][word];
            end
            default: next_state = IDLE;
        endcase
        case (state_q)
            WB0:     next_state = WB1;
            WB1:     next_state = WB2;
            WB2:     next_state = WB3;
            WB3:     next_state = RD0;
            RD0:     next_state = RD1;
            RD1:     next_state = RD2;
            RD2:     next_state = RD3;
            RD3:     next_state = WAIT0;
            WAIT0:   next_state = WAIT1;
            WAIT1:   next_state = DONE;
            default: ;
        endcase
    end

    assign Done     = rst & done_c;
    assign Stall    = rst & stall_c;
    assign CacheHit = rst & hit_c;
    assign DataOut  = rst ? data_c : 16'h0000;

    main_mem u_main_mem (
        .clk    (clk),
        .rst    (rst),
        .rd     (mem_rd),
        .wr     (mem_wr),
        .addr   (mem_addr),
        .wdata  (mem_wdata),
        .rdata  (mem_rdata),
        .rvalid (mem_rvalid)
    );

endmodule

// File: tb/tb_mem_system.sv
// Bench for mem_system: directed cases plus random traffic against a recency-list
// cache model backed by a processor-visible shadow image and a main-memory image.
module tb_mem_system;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Rd = 1'b0, Wr = 1'b0;
    logic [15:0] Addr = 16'h0, DataIn = 16'h0;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit;

    always #5 clk = ~clk;

    mem_system dut (
        .clk      (clk),
        .rst      (rst),
        .Addr     (Addr),
        .DataIn   (DataIn),
        .Rd       (Rd),
        .Wr       (Wr),
        .DataOut  (DataOut),
        .Done     (Done),
        .Stall    (Stall),
        .CacheHit (CacheHit)
    );

    int          total = 0;
    int          bad = 0;
    logic [15:0] shadow  [32768];
    logic [15:0] mem_img [32768];
    int          n_lines [32];
    logic [7:0]  lt [32][2];
    bit          ld [32][2];
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int waddr(input logic [7:0] t, input int s, input int k);
        return (int'(t) << 7) | (s << 2) | k;
    endfunction

    // Reset drops every dirty line, so the visible image reverts to main memory there.
    task automatic model_reset();
        for (int s = 0; s < 32; s++) begin
            for (int i = 0; i < n_lines[s]; i++) begin
                if (ld[s][i]) begin
                    for (int k = 0; k < 4; k++) shadow[waddr(lt[s][i], s, k)] = mem_img[waddr(lt[s][i], s, k)];
                end
            end
            n_lines[s] = 0;
        end
    endtask

    // Index 0 of each set list is most recently used, index 1 least recently used.
    task automatic model_access(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                                output bit hit, output int lat);
        int         s;
        int         wa;
        int         pos;
        logic [7:0] t;
        logic [7:0] tt;
        bit         td;
        s   = int'(a[7:3]);
        t   = a[15:8];
        wa  = int'(a[15:1]);
        pos = -1;
        for (int i = 0; i < n_lines[s]; i++) if (lt[s][i] == t) pos = i;
        if (pos >= 0) begin
            hit = 1'b1;
            lat = 0;
            if (pos == 1) begin
                tt = lt[s][0]; td = ld[s][0];
                lt[s][0] = lt[s][1]; ld[s][0] = ld[s][1];
                lt[s][1] = tt; ld[s][1] = td;
            end
            if (is_wr) ld[s][0] = 1'b1;
        end else begin
            hit = 1'b0;
            lat = 7;
            if (n_lines[s] == 2 && ld[s][1]) begin
                lat = 11;
                for (int k = 0; k < 4; k++) mem_img[waddr(lt[s][1], s, k)] = shadow[waddr(lt[s][1], s, k)];
            end
            lt[s][1] = lt[s][0]; ld[s][1] = ld[s][0];
            lt[s][0] = t;        ld[s][0] = is_wr;
            if (n_lines[s] < 2) n_lines[s]++;
        end
        if (is_wr) shadow[wa] = d;
        exp_q.push_back(is_wr ? 16'h0000 : shadow[wa]);
    endtask

    // Entered just after a rising edge; returns just after the edge that ends Done.
    task automatic do_req(input bit is_wr, input logic [15:0] a, input logic [15:0] d);
        bit          hit;
        int          lat;
        int          cyc;
        bit          seen;
        logic [15:0] exp_d;
        model_access(is_wr, a, d, hit, lat);
        Rd = !is_wr; Wr = is_wr; Addr = a; DataIn = d;
        cyc = 0;
        @(negedge clk);
        check("stall_at_request", 32'(Stall), 32'(!hit));
        while (!Done && cyc < 25) begin
            cyc++;
            @(negedge clk);
        end
        seen  = Done;
        exp_d = exp_q.pop_front();
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(cyc), 32'(lat));
            check("cache_hit", 32'(CacheHit), 32'(hit));
            check("data_out", 32'(DataOut), 32'(exp_d));
            check("stall_at_done", 32'(Stall), 32'd0);
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("no_done_idle", 32'(Done), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_mid_fill(input logic [15:0] a);
        Rd = 1'b1; Addr = a;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; Rd = 1'b0;
        @(negedge clk);
        check("outputs_in_reset", {13'd0, Done, Stall, CacheHit, DataOut}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("no_done_after_abort", 32'(Done), 32'd0);
        check("stall_after_abort", 32'(Stall), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rt;
        logic [4:0]  ri;
        logic [1:0]  rw;
        logic        rb;
        bit          w;
        for (int i = 0; i < 32768; i++) begin
            shadow[i]  = 16'h0;
            mem_img[i] = 16'h0;
        end
        for (int s = 0; s < 32; s++) n_lines[s] = 0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {13'd0, Done, Stall, CacheHit, DataOut}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        do_req(1'b0, 16'h0000, 16'h0);
        do_req(1'b0, 16'h0000, 16'h0);
        do_req(1'b1, 16'h0010, 16'h1234);
        do_req(1'b0, 16'h0012, 16'h0);
        do_req(1'b0, 16'h0010, 16'h0);
        idle(2);

        do_req(1'b1, 16'h0110, 16'hAAAA);
        do_req(1'b1, 16'h0210, 16'hBBBB);
        do_req(1'b0, 16'h0310, 16'h0);
        do_req(1'b0, 16'h0110, 16'h0);

        do_req(1'b0, 16'h0310, 16'h0);
        do_req(1'b0, 16'h0410, 16'h0);
        do_req(1'b0, 16'h0310, 16'h0);
        do_req(1'b0, 16'h0110, 16'h0);

        reset_mid_fill(16'h00F8);
        do_req(1'b0, 16'h00F8, 16'h0);
        do_req(1'b0, 16'h0010, 16'h0);

        for (int r = 0; r < 1000; r++) begin
            w  = 1'($urandom_range(0, 1));
            rt = 8'($urandom_range(0, 3));
            ri = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            rw = 2'($urandom_range(0, 3));
            rb = 1'($urandom_range(0, 1));
            do_req(w, {rt, ri, rw, rb}, 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
